// File: rtl/data_mem_ctrl.sv
// RV32 data-memory stage: byte-addressed little-endian array serving LB/LBU/LH/LHU/LW/SB/SH/SW.
// Response pulses LATENCY+1 cycles after acceptance; one request in flight, req_ready low until IDLE.
module data_mem_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  misaligned,
  output logic                  busy
);

  localparam int         DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] LAT   = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic                  we;
    logic [1:0]            size;
    logic                  uns;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  logic [7:0] mem [DEPTH];

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  req_t in_req, q, cur;
  logic accept, commit, cur_mis, wr_en;
  logic [ADDR_WIDTH-1:0] a0, a1, a2, a3;
  logic [DATA_WIDTH-1:0] raw, load_val;
  logic unused_addr_hi;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = lo[0];
      2'b10:   is_misaligned = (lo != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] load_ext(input logic [1:0] size, input logic uns,
                                                    input logic [DATA_WIDTH-1:0] w);
    case (size)
      2'b00:   load_ext = uns ? {{(DATA_WIDTH-8){1'b0}}, w[7:0]}
                              : {{(DATA_WIDTH-8){w[7]}}, w[7:0]};
      2'b01:   load_ext = uns ? {{(DATA_WIDTH-16){1'b0}}, w[15:0]}
                              : {{(DATA_WIDTH-16){w[15]}}, w[15:0]};
      default: load_ext = w;
    endcase
  endfunction

  // Upper address bits alias onto the array and are intentionally dropped.
  assign unused_addr_hi = ^addr[DATA_WIDTH-1:ADDR_WIDTH];

  assign in_req = '{we: req_we, size: req_size, uns: req_unsigned,
                    addr: addr[ADDR_WIDTH-1:0], wdata: wdata};

  assign req_ready = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;

  // With zero latency the commit happens on the accepting edge, so work from the live request.
  assign cur     = (state == IDLE) ? in_req : q;
  assign cur_mis = is_misaligned(cur.size, cur.addr[1:0]);
  assign commit  = !rst && ((accept && (LAT == 4'd0)) || ((state == WAIT) && (cnt == 4'd1)));
  assign wr_en   = commit && cur.we && !cur_mis;

  assign a0 = cur.addr;
  assign a1 = cur.addr + ADDR_WIDTH'(1);
  assign a2 = cur.addr + ADDR_WIDTH'(2);
  assign a3 = cur.addr + ADDR_WIDTH'(3);

  assign raw      = {mem[a3], mem[a2], mem[a1], mem[a0]};
  assign load_val = load_ext(cur.size, cur.uns, raw);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_nxt   = LAT;
          state_nxt = (LAT == 4'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      rsp_valid  <= 1'b0;
      rdata      <= '0;
      misaligned <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rsp_valid <= commit;
      if (commit) begin
        rdata      <= (cur.we || cur_mis) ? '0 : load_val;
        misaligned <= cur_mis;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) q <= in_req;
  end

  // Byte lanes beyond the access size keep their old contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[a0] <= cur.wdata[7:0];
      if (cur.size != 2'b00) mem[a1] <= cur.wdata[15:8];
      if (cur.size == 2'b10) begin
        mem[a2] <= cur.wdata[23:16];
        mem[a3] <= cur.wdata[31:24];
      end
    end
  end

endmodule
